// File: rtl/root_stream_writer.sv
// Serializes a snapshot of the decoder root bus into a 32-bit valid/ready word stream:
// test-ID header, one packed root word per PU, and an optional trailer (ROOT_STREAM_TRAILER_EN).
module root_stream_writer #(
    parameter int CODE_DISTANCE_X = 3,
    parameter int CODE_DISTANCE_Z = 2,
    localparam int MEASUREMENT_ROUNDS = (CODE_DISTANCE_X > CODE_DISTANCE_Z) ? CODE_DISTANCE_X : CODE_DISTANCE_Z,
    localparam int PU_COUNT = CODE_DISTANCE_X * CODE_DISTANCE_Z * MEASUREMENT_ROUNDS,
    localparam int PER_DIM_WIDTH = $clog2(MEASUREMENT_ROUNDS),
    localparam int ADDRESS_WIDTH = 3 * PER_DIM_WIDTH
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                result_valid,
    input  logic [ADDRESS_WIDTH*PU_COUNT-1:0]   roots,
    input  logic [31:0]                         test_id,
    input  logic [31:0]                         cycle_counter,
    input  logic [7:0]                          iteration_counter,
    output logic [31:0]                         out_data,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic                                busy,
    output logic                                dropped,
    output logic [7:0]                          drop_count
);

    localparam int IDX_W = (PU_COUNT > 1) ? $clog2(PU_COUNT) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PU_COUNT - 1);

`ifdef ROOT_STREAM_TRAILER_EN
    typedef enum logic [1:0] {S_IDLE, S_HEADER, S_ROOTS, S_TRAILER} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_HEADER, S_ROOTS} state_t;
`endif

    // Stream handshake: a word moves on any rising clk where out_valid && out_ready;
    // out_valid/out_data only change after a transfer (never withdrawn while stalled).
    state_t                              state;
    logic                                valid_d;
    logic [ADDRESS_WIDTH*PU_COUNT-1:0]   roots_q;
    logic [IDX_W-1:0]                    word_idx;
    logic [ADDRESS_WIDTH-1:0]            root_arr [PU_COUNT];
    logic                                edge_seen;
    logic                                hs;

`ifdef ROOT_STREAM_TRAILER_EN
    logic [31:0] trailer_q;
    logic        unused_inputs;
    assign unused_inputs = ^cycle_counter[31:24];
`else
    logic        unused_inputs;
    assign unused_inputs = ^{cycle_counter, iteration_counter};
`endif

    for (genvar n = 0; n < PU_COUNT; n++) begin : g_root_arr
        assign root_arr[n] = roots_q[ADDRESS_WIDTH*n +: ADDRESS_WIDTH];
    end

    assign edge_seen = result_valid && !valid_d;
    assign hs        = out_valid && out_ready;
    assign busy      = (state != S_IDLE);

    // Root entry {z,x,y} spread into byte lanes: y -> [7:0], x -> [15:8], z -> [23:16].
    function automatic logic [31:0] pack_root(input logic [ADDRESS_WIDTH-1:0] a);
        logic [31:0] w;
        w = '0;
        w[PER_DIM_WIDTH-1:0]  = a[PER_DIM_WIDTH-1:0];
        w[8 +: PER_DIM_WIDTH]  = a[PER_DIM_WIDTH +: PER_DIM_WIDTH];
        w[16 +: PER_DIM_WIDTH] = a[2*PER_DIM_WIDTH +: PER_DIM_WIDTH];
        return w;
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            valid_d    <= 1'b0;
            roots_q    <= '0;
            word_idx   <= '0;
            out_data   <= '0;
            out_valid  <= 1'b0;
            dropped    <= 1'b0;
            drop_count <= '0;
`ifdef ROOT_STREAM_TRAILER_EN
            trailer_q  <= '0;
`endif
        end else begin
            valid_d <= result_valid;
            dropped <= 1'b0;
            // An edge arriving while any word is still owed is lost, last-handshake cycle included.
            if (edge_seen && state != S_IDLE) begin
                dropped <= 1'b1;
                if (drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
            end
            case (state)
                S_IDLE: begin
                    if (edge_seen) begin
                        roots_q   <= roots;
                        word_idx  <= '0;
                        out_data  <= test_id;
                        out_valid <= 1'b1;
                        state     <= S_HEADER;
`ifdef ROOT_STREAM_TRAILER_EN
                        trailer_q <= {iteration_counter, cycle_counter[23:0]};
`endif
                    end
                end
                S_HEADER: begin
                    if (hs) begin
                        out_data <= pack_root(root_arr[word_idx]);
                        state    <= S_ROOTS;
                    end
                end
                S_ROOTS: begin
                    if (hs) begin
                        if (word_idx == LAST_IDX) begin
`ifdef ROOT_STREAM_TRAILER_EN
                            out_data  <= trailer_q;
                            state     <= S_TRAILER;
`else
                            out_data  <= '0;
                            out_valid <= 1'b0;
                            state     <= S_IDLE;
`endif
                        end else begin
                            word_idx <= word_idx + 1'b1;
                            out_data <= pack_root(root_arr[word_idx + 1'b1]);
                        end
                    end
                end
`ifdef ROOT_STREAM_TRAILER_EN
                S_TRAILER: begin
                    if (hs) begin
                        out_data  <= '0;
                        out_valid <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
`endif
                default: begin
                    out_valid <= 1'b0;
                    state     <= S_IDLE;
                end
            endcase
        end
    end

endmodule
